// File: rtl/and_share_arbiter.sv
// Round-robin arbiter time-sharing one W-bit AND unit among NUM_REQ requesters.
// One registered response slot; the winner's ID travels with each result.
module and_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int W       = 8,
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*W-1:0] req_a,
  input  logic [NUM_REQ*W-1:0] req_b,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 rsp_valid,
  output logic [W-1:0]         rsp_data,
  output logic [ID_W-1:0]      rsp_id,
  input  logic                 rsp_ready,
  output logic                 dbg_state
);

  // Handshakes: a request transfers at posedge when req_valid[i] & req_ready[i];
  // the response transfers at posedge when rsp_valid & rsp_ready.
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    rsp_data_q, rsp_data_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [ID_W-1:0] ptr_q, ptr_d;

  logic            can_issue;
  logic            grant_found;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W-1:0] scan_idx;
  logic [W-1:0]    op_a, op_b;
  logic            xfer;
  int              scan_sum;
  int              next_ptr;

  assign can_issue = (state_q == EMPTY) | rsp_ready;

  // Rotating priority scan starting at ptr_q.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    scan_sum    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_sum = int'(ptr_q) + k;
      if (scan_sum >= NUM_REQ) scan_sum = scan_sum - NUM_REQ;
      scan_idx = ID_W'(scan_sum);
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  assign xfer = grant_found & can_issue & ~rst;

  always_comb begin
    req_ready = '0;
    op_a      = '0;
    op_b      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        req_ready[i] = xfer;
        op_a         = req_a[i*W +: W];
        op_b         = req_b[i*W +: W];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    ptr_d      = ptr_q;
    next_ptr   = int'(grant_idx) + 1;
    if (next_ptr >= NUM_REQ) next_ptr = 0;
    if (xfer) begin
      state_d    = FULL;
      rsp_data_d = op_a & op_b;
      rsp_id_d   = grant_idx;
      ptr_d      = ID_W'(next_ptr);
    end else if (state_q == FULL && rsp_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
      ptr_q      <= '0;
    end else begin
      state_q    <= state_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
      ptr_q      <= ptr_d;
    end
  end

  assign rsp_valid = (state_q == FULL);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign dbg_state = state_q;

endmodule
